bcd_display_scan: RTL and testbench
===================================

// Module: bcd_display_scan
// PURPOSE
//  Time-multiplexed 8-digit 7-segment driver fed by the binary-to-BCD converter's 32-bit packed BCD word.
//  - Latches a new BCD word on a valid strobe and commits it only at a frame boundary, so a scan frame never tears.
//  - Scans digits 0..7, one per refresh tick, and drives active-low anodes and segments on the board display.
// PARAMETERS
//  NUM_DIGITS  8      digits scanned; bcd_in width = 4*NUM_DIGITS (fixed at 8 in this revision)
//  TICK_DIV    50000  clk cycles per digit slot (1 kHz digit rate at 50 MHz); legal range >= 2
//  CNT_W       16     prescaler width; must satisfy 2**CNT_W >= TICK_DIV
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  bcd_in      in   32  packed BCD, digit k = bcd_in[4k+3:4k], digit 0 = least significant
//  bcd_valid   in   1   one-cycle strobe: capture bcd_in
//  blank_lz    in   1   1 = blank leading zeros (digit 0 never blanked)
//  dp_mask     in   8   decimal-point enable per digit, sampled live
//  an          out  8   anode enables, active-low, one-hot-low while scanning
//  seg         out  7   {g,f,e,d,c,b,a}, active-low
//  dp          out  1   decimal point, active-low
//  frame_done  out  1   one-cycle pulse when digit 7 slot ends (index wraps 7->0)
// BEHAVIOUR
//  Reset (async assert, sync release): an=8'hFF, seg=7'h7F, dp=1, frame_done=0, prescaler=0, idx=0,
//   pending=0, pend_vld=0, shown=32'h0. The first slot after release is digit 0.
//  Prescaler: counts 0..TICK_DIV-1; tick=1 on the cycle it equals TICK_DIV-1, then wraps to 0.
//  Digit index idx (3 bit): increments on tick, wraps 7->0. frame_done=1 on the tick cycle where idx==7.
//  Capture: bcd_valid=1 -> pending<=bcd_in, pend_vld<=1. A later strobe overwrites pending (last wins).
//  Commit: on frame_done cycle with pend_vld=1 -> shown<=pending, pend_vld<=0.
//   - If bcd_valid is also asserted on that same cycle, shown<=bcd_in directly, pend_vld<=0.
//   - No bcd_valid ever leaves the display showing 00000000 (digit 0 lit as "0", others per blank_lz).
//  Outputs are registered: an/seg/dp reflect idx and shown one cycle after idx changes.
//   an[idx]=0, all other bits 1.
//  Decode digit value v = shown[4*idx+3:4*idx]:
//   - v 0..9 gives the standard pattern (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19,
//     5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10).
//   - v 10..15 is illegal BCD: show a dash, 7'h3F (segment g only).
//  Leading-zero blanking, when blank_lz=1:
//   - Digit k is blank if k > msd, where msd = highest index with nonzero nibble (msd=0 if all zero).
//   - Blank means seg=7'h7F and dp=1, but the anode is still driven, so brightness stays uniform.
//   - Illegal nibbles count as nonzero.
//  dp = ~dp_mask[idx], forced to 1 when the digit is blanked.
//  Reset mid-frame: all state returns to reset values immediately; pending data is discarded.
// STRUCTURE
//  Include file seg7_defs.vh:
//   - SEG_* pattern localparams for 0-9, SEG_DASH, SEG_OFF.
//   - AN_OFF, and the digit-width define BCD_DIGIT_W=4.
//  Sub-module seg7_decode: combinational nibble+blank -> 7-bit active-low pattern.
//   - Instantiated once, on the muxed digit.
//  Top level holds the prescaler, idx, the pending/shown registers, the msd priority encoder and the output registers.
// TESTING (bench uses TICK_DIV=4)
//  1 Reset: hold rst_n=0, then release -> an=FF, seg=7F during reset; the first tick starts digit 0 showing "0" (seg=40).
//  2 Strobe bcd_in=32'h00001234 with blank_lz=0, wait for the boundary:
//    - next frame gives an FE/FD/FB/F7 with seg 19/30/24/79; digits 4-7 show seg=40.
//  3 Same value with blank_lz=1 -> digits 4-7: seg=7F, dp=1, and their anodes still pulse low once each.
//  4 Strobe mid-frame -> the current frame is unchanged; the new value appears starting at digit 0 of the next frame.
//    Two strobes within one frame (0x11, then 0x22) -> only 0x22 is displayed.
//  5 bcd_valid coincident with frame_done, bcd_in=32'h99999999 -> all digits show seg=10 in the very next frame.
//  6 Illegal nibble: bcd_in=32'h0000A0F5 -> digit 1 and digit 3 show 3F; with blank_lz=1, digits 4-7 are blank.
//    Assert rst_n=0 mid-frame -> an=FF the same cycle, and the shown value returns to 0.

Source files
------------

// File: rtl/bcd_display_scan_pkg.sv
// Common constants for the multiplexed BCD display driver.
package bcd_display_scan_pkg;

`include "seg7_defs.vh"

    // Bits per packed BCD digit.
    localparam int DIGIT_W = `BCD_DIGIT_W;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble -> active-low 7-segment pattern, with blanking.
module seg7_decode
    import bcd_display_scan_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic               blank_i,
    output logic [6:0]         seg_o
);

    // Blank wins over any digit value; non-BCD nibbles render as a dash.
    always_comb begin
        seg_o = SEG_OFF;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg7_defs.vh
// Shared 7-segment constants: active-low patterns in {g,f,e,d,c,b,a} order.
`ifndef SEG7_DEFS_VH
`define SEG7_DEFS_VH

`define BCD_DIGIT_W 4

localparam logic [6:0] SEG_0    = 7'h40;
localparam logic [6:0] SEG_1    = 7'h79;
localparam logic [6:0] SEG_2    = 7'h24;
localparam logic [6:0] SEG_3    = 7'h30;
localparam logic [6:0] SEG_4    = 7'h19;
localparam logic [6:0] SEG_5    = 7'h12;
localparam logic [6:0] SEG_6    = 7'h02;
localparam logic [6:0] SEG_7    = 7'h78;
localparam logic [6:0] SEG_8    = 7'h00;
localparam logic [6:0] SEG_9    = 7'h10;
// Segment g only: marks a nibble that is not valid BCD.
localparam logic [6:0] SEG_DASH = 7'h3F;
localparam logic [6:0] SEG_OFF  = 7'h7F;
localparam logic [7:0] AN_OFF   = 8'hFF;

`endif

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 8-digit 7-segment driver. A new BCD word is held as
// pending and only committed to the displayed word at a frame boundary,
// so one scan frame always shows a single consistent value.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 50000,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] bcd_in,
    input  logic                          bcd_valid,
    input  logic                          blank_lz,
    input  logic [NUM_DIGITS-1:0]         dp_mask,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic                          frame_done
);

    localparam int                 IDX_W    = $clog2(NUM_DIGITS);
    localparam int                 BCD_W    = NUM_DIGITS * DIGIT_W;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BCD_W-1:0]      pending_q, pending_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [BCD_W-1:0]      shown_q, shown_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  tick;
    logic [DIGIT_W-1:0]    cur_digit;
    logic [IDX_W-1:0]      msd;
    logic                  blank;

    assign tick       = (cnt_q == CNT_LAST);
    assign frame_done = tick && (idx_q == IDX_LAST);

    // Prescaler and digit index advance; the index moves once per slot.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Capture into pending on a strobe; commit to shown only at frame end.
    // A strobe landing on the boundary cycle bypasses pending entirely.
    always_comb begin
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        shown_d    = shown_q;
        if (frame_done) begin
            if (bcd_valid) begin
                shown_d = bcd_in;
            end else if (pend_vld_q) begin
                shown_d = pending_q;
            end
            pend_vld_d = 1'b0;
        end else if (bcd_valid) begin
            pending_d  = bcd_in;
            pend_vld_d = 1'b1;
        end
    end

    // Select the nibble of the digit currently being scanned.
    always_comb begin
        cur_digit = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_digit = shown_q[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // Most significant nonzero digit; illegal nibbles count as nonzero.
    always_comb begin
        msd = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (shown_q[k*DIGIT_W +: DIGIT_W] != '0) begin
                msd = IDX_W'(k);
            end
        end
    end

    assign blank = blank_lz && (idx_q > msd);

    seg7_decode u_decode (
        .digit_i (cur_digit),
        .blank_i (blank),
        .seg_o   (seg_d)
    );

    // Next output values: one low anode, dp live from the mask unless blanked.
    always_comb begin
        an_d        = '1;
        an_d[idx_q] = 1'b0;
        dp_d        = blank | ~dp_mask[idx_q];
    end

    // State and output registers; reset drops all pending data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            shown_q    <= '0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            shown_q    <= shown_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: directed scenarios plus random strobes, checked
// by a frame-level reference model feeding an expected queue.
module tb_bcd_display_scan;

    localparam int TICK  = 4;
    localparam int NDIG  = 8;
    localparam int FRAME = TICK * NDIG;

    logic        clk;
    logic        rst_n;
    logic [31:0] bcd_in;
    logic        bcd_valid;
    logic        blank_lz;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // expected {an, seg, dp} per digit slot
    logic [15:0] exp_q[$];

    // reference model state
    int unsigned k_edges = 0;
    logic [31:0] m_shown = '0;
    logic [31:0] m_pend  = '0;
    bit          m_pv    = 0;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bcd_display_scan #(
        .NUM_DIGITS (8),
        .TICK_DIV   (TICK),
        .CNT_W      (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // What digit d of word sh looks like on the display.
    function automatic logic [15:0] expect_slot(input int d, input logic [31:0] sh,
                                                input logic bl, input logic [7:0] dm);
        int         msd;
        logic [3:0] v;
        logic [7:0] a;
        logic [6:0] s;
        logic       p;
        msd = 0;
        for (int i = 0; i < NDIG; i++) begin
            if (((sh >> (4 * i)) & 32'hF) != 0) msd = i;
        end
        v    = 4'((sh >> (4 * d)) & 32'hF);
        a    = 8'hFF;
        a[d] = 1'b0;
        if (bl && d > msd) begin
            s = 7'h7F;
            p = 1'b1;
        end else begin
            s = (v < 10) ? seg_tbl[v] : 7'h3F;
            p = ~dm[d];
        end
        return {a, s, p};
    endfunction

    // ---------------- reference model ----------------
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                k_edges = 0;
                m_shown = '0;
                m_pend  = '0;
                m_pv    = 0;
                exp_q.delete();
            end else begin
                if (k_edges % TICK == 0)
                    exp_q.push_back(expect_slot((k_edges / TICK) % NDIG, m_shown, blank_lz, dp_mask));
                if (k_edges % FRAME == FRAME - 1) begin
                    if (bcd_valid) m_shown = bcd_in;
                    else if (m_pv) m_shown = m_pend;
                    m_pv = 0;
                end else if (bcd_valid) begin
                    m_pend = bcd_in;
                    m_pv   = 1;
                end
                k_edges++;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [7:0]  prev_an;
        logic [15:0] e;
        prev_an = 8'hFF;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_an = 8'hFF;
            end else begin
                chk("frame_done", {31'b0, frame_done},
                    {31'b0, (k_edges % FRAME == FRAME - 1)});
                if (an !== prev_an) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_slot", {8'b0, an, seg, dp}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("slot_an",  {24'b0, an},        {24'b0, e[15:8]});
                        chk("slot_seg", {25'b0, seg},       {25'b0, e[7:1]});
                        chk("slot_dp",  {31'b0, dp},        {31'b0, e[0]});
                    end
                    prev_an = an;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [31:0] v);
        @(negedge clk);
        bcd_in    = v;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
    endtask

    // Leaves the bench at the negedge just before a frame-boundary edge.
    task automatic wait_fd();
        bit found;
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (frame_done) found = 1;
        end
        if (!found) chk("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic strobe_on_boundary(input logic [31:0] v);
        wait_fd();
        bcd_in    = v;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int i = 0; i < NDIG; i++) w[4*i +: 4] = 4'($urandom_range(0, 11));
        if ($urandom_range(0, 2) == 0) w = w & 32'h0000_FFFF;
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        bcd_in    = '0;
        bcd_valid = 1'b0;
        blank_lz  = 1'b0;
        dp_mask   = '0;

        // reset state
        cycles(3);
        chk("reset_an",         {24'b0, an},  32'hFF);
        chk("reset_seg",        {25'b0, seg}, 32'h7F);
        chk("reset_dp",         {31'b0, dp},  32'h1);
        chk("reset_frame_done", {31'b0, frame_done}, 32'h0);
        rst_n = 1'b1;
        cycles(FRAME + 4);

        // 1234, no blanking, then with blanking and dp on every digit
        strobe(32'h0000_1234);
        cycles(2 * FRAME);
        blank_lz = 1'b1;
        cycles(FRAME);
        dp_mask = 8'hFF;
        cycles(FRAME);
        dp_mask = 8'h05;

        // two strobes mid-frame: last one wins at next boundary
        wait_fd();
        cycles(10);
        strobe(32'h0000_0011);
        cycles(3);
        strobe(32'h0000_0022);
        cycles(2 * FRAME);

        // strobe coincident with frame boundary
        strobe_on_boundary(32'h9999_9999);
        cycles(FRAME + 2);

        // illegal nibbles, both blanking modes
        blank_lz = 1'b0;
        strobe(32'h0000_A0F5);
        cycles(2 * FRAME);
        blank_lz = 1'b1;
        cycles(FRAME);

        // reset mid-frame: anodes off at once, display back to zero
        cycles(13);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_an",  {24'b0, an},  32'hFF);
        chk("midreset_seg", {25'b0, seg}, 32'h7F);
        chk("midreset_dp",  {31'b0, dp},  32'h1);
        cycles(3);
        rst_n = 1'b1;
        cycles(FRAME + 4);

        // random strobes, blanking and dp changes
        for (int it = 0; it < 40; it++) begin
            blank_lz = 1'($urandom_range(0, 1));
            dp_mask  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) strobe_on_boundary(rand_word());
            else begin
                cycles($urandom_range(0, 40));
                strobe(rand_word());
            end
        end
        cycles(2 * FRAME);

        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
